// File: rtl/ecc_scalar_mul_ctrl.sv
// MSB-first double-and-add sequencer computing Q = k*P over external doubler/adder units.
// Optional watchdog on sub-operation waits: define ECC_SMUL_WATCHDOG_EN.
module ecc_scalar_mul_ctrl #(
    parameter int W       = 256,
    parameter int TIMEOUT = 65535
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_k,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic         o_dbl_start,
    output logic [W-1:0] o_dbl_x,
    output logic [W-1:0] o_dbl_y,
    input  logic         i_dbl_finish,
    input  logic [W-1:0] i_dbl_x,
    input  logic [W-1:0] i_dbl_y,
    output logic         o_add_start,
    output logic [W-1:0] o_add_x1,
    output logic [W-1:0] o_add_y1,
    output logic [W-1:0] o_add_x2,
    output logic [W-1:0] o_add_y2,
    input  logic         i_add_finish,
    input  logic [W-1:0] i_add_x,
    input  logic [W-1:0] i_add_y,
    output logic         o_busy,
    output logic         o_finished,
    output logic [W-1:0] o_result_x,
    output logic [W-1:0] o_result_y,
    output logic         o_error
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCAN     = 3'd1;
    localparam logic [2:0] S_NEXT     = 3'd2;
    localparam logic [2:0] S_DBL_REQ  = 3'd3;
    localparam logic [2:0] S_DBL_WAIT = 3'd4;
    localparam logic [2:0] S_ADD_REQ  = 3'd5;
    localparam logic [2:0] S_ADD_WAIT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam int          CW       = $clog2(W + 1);
    localparam logic [W-1:0] ALL_ONES = '1;

    logic [2:0]    state_reg;
    logic [W-1:0]  k_reg, px_reg, py_reg, rx_reg, ry_reg;
    logic [W-1:0]  res_x_reg, res_y_reg;
    logic [CW-1:0] cnt_reg;
    logic          dbl_start_reg, add_start_reg, busy_reg, fin_reg;

`ifdef ECC_SMUL_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_reg;
    logic           err_reg;
    assign o_error = err_reg;
`else
    assign o_error = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            px_reg        <= '0;
            py_reg        <= '0;
            rx_reg        <= '0;
            ry_reg        <= '0;
            res_x_reg     <= '0;
            res_y_reg     <= '0;
            cnt_reg       <= '0;
            dbl_start_reg <= 1'b0;
            add_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
            fin_reg       <= 1'b0;
`ifdef ECC_SMUL_WATCHDOG_EN
            wd_reg        <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            // Start/finish strobes are single-cycle unless re-asserted below.
            dbl_start_reg <= 1'b0;
            add_start_reg <= 1'b0;
            fin_reg       <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        k_reg     <= i_k;
                        px_reg    <= i_x;
                        py_reg    <= i_y;
                        cnt_reg   <= CW'(W);
                        busy_reg  <= 1'b1;
`ifdef ECC_SMUL_WATCHDOG_EN
                        err_reg   <= 1'b0;
`endif
                        state_reg <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (k_reg == '0) begin
                        rx_reg    <= ALL_ONES;
                        ry_reg    <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        if (k_reg[W-1]) begin
                            rx_reg    <= px_reg;
                            ry_reg    <= py_reg;
                            state_reg <= S_NEXT;
                        end
                        k_reg   <= k_reg << 1;
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                S_NEXT: begin
                    state_reg <= (cnt_reg == '0) ? S_DONE : S_DBL_REQ;
                end
                S_DBL_REQ: begin
                    dbl_start_reg <= 1'b1;
`ifdef ECC_SMUL_WATCHDOG_EN
                    wd_reg        <= '0;
`endif
                    state_reg     <= S_DBL_WAIT;
                end
                S_DBL_WAIT: begin
                    if (i_dbl_finish) begin
                        rx_reg <= i_dbl_x;
                        ry_reg <= i_dbl_y;
                        if (k_reg[W-1]) begin
                            state_reg <= S_ADD_REQ;
                        end else begin
                            k_reg     <= k_reg << 1;
                            cnt_reg   <= cnt_reg - CW'(1);
                            state_reg <= S_NEXT;
                        end
                    end
`ifdef ECC_SMUL_WATCHDOG_EN
                    else if (wd_reg == WDW'(TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        rx_reg    <= ALL_ONES;
                        ry_reg    <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        wd_reg <= wd_reg + WDW'(1);
                    end
`endif
                end
                S_ADD_REQ: begin
                    // R at infinity: infinity + P = P, so the adder is bypassed.
                    if (rx_reg == ALL_ONES) begin
                        rx_reg    <= px_reg;
                        ry_reg    <= py_reg;
                        k_reg     <= k_reg << 1;
                        cnt_reg   <= cnt_reg - CW'(1);
                        state_reg <= S_NEXT;
                    end else begin
                        add_start_reg <= 1'b1;
`ifdef ECC_SMUL_WATCHDOG_EN
                        wd_reg        <= '0;
`endif
                        state_reg     <= S_ADD_WAIT;
                    end
                end
                S_ADD_WAIT: begin
                    if (i_add_finish) begin
                        rx_reg    <= i_add_x;
                        ry_reg    <= i_add_y;
                        k_reg     <= k_reg << 1;
                        cnt_reg   <= cnt_reg - CW'(1);
                        state_reg <= S_NEXT;
                    end
`ifdef ECC_SMUL_WATCHDOG_EN
                    else if (wd_reg == WDW'(TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        rx_reg    <= ALL_ONES;
                        ry_reg    <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        wd_reg <= wd_reg + WDW'(1);
                    end
`endif
                end
                S_DONE: begin
                    res_x_reg <= rx_reg;
                    res_y_reg <= ry_reg;
                    fin_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign o_dbl_start = dbl_start_reg;
    assign o_dbl_x     = rx_reg;
    assign o_dbl_y     = ry_reg;
    assign o_add_start = add_start_reg;
    assign o_add_x1    = rx_reg;
    assign o_add_y1    = ry_reg;
    assign o_add_x2    = px_reg;
    assign o_add_y2    = py_reg;
    assign o_busy      = busy_reg;
    assign o_finished  = fin_reg;
    assign o_result_x  = res_x_reg;
    assign o_result_y  = res_y_reg;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Directed bench: integer stub units (2R, R+P) make Q = (k*Px, k*Py) mod 2^W easy to predict.
`timescale 1ns/1ps
module tb_ecc_scalar_mul_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_k = '0, i_x = '0, i_y = '0;
    logic         o_dbl_start, o_add_start, o_busy, o_finished, o_error;
    logic [W-1:0] o_dbl_x, o_dbl_y, o_add_x1, o_add_y1, o_add_x2, o_add_y2;
    logic [W-1:0] o_result_x, o_result_y;
    logic         i_dbl_finish = 1'b0, i_add_finish = 1'b0;
    logic [W-1:0] i_dbl_x = '0, i_dbl_y = '0, i_add_x = '0, i_add_y = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecc_scalar_mul_ctrl #(.W(W), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_k(i_k), .i_x(i_x), .i_y(i_y),
        .o_dbl_start(o_dbl_start), .o_dbl_x(o_dbl_x), .o_dbl_y(o_dbl_y),
        .i_dbl_finish(i_dbl_finish), .i_dbl_x(i_dbl_x), .i_dbl_y(i_dbl_y),
        .o_add_start(o_add_start), .o_add_x1(o_add_x1), .o_add_y1(o_add_y1),
        .o_add_x2(o_add_x2), .o_add_y2(o_add_y2),
        .i_add_finish(i_add_finish), .i_add_x(i_add_x), .i_add_y(i_add_y),
        .o_busy(o_busy), .o_finished(o_finished),
        .o_result_x(o_result_x), .o_result_y(o_result_y), .o_error(o_error)
    );

    // Stub units: fixed latency, log every request in order.
    logic         dbl_hang = 1'b0;
    logic         dbl_pend = 1'b0, add_pend = 1'b0;
    int           dbl_dly = 0, add_dly = 0;
    logic [W-1:0] dx, dy, ax1, ay1, ax2, ay2;
    int           n_dbl = 0, n_add = 0, alt_bad = 0, fin_cnt = 0;
    logic [1:0]   last_op = 2'd0;
    logic [31:0]  ops_seq = '0;

    always @(negedge clk) begin
        i_dbl_finish = 1'b0;
        i_add_finish = 1'b0;
        if (dbl_pend) begin
            if (dbl_dly == 0) begin
                i_dbl_finish = 1'b1;
                i_dbl_x = dx << 1;
                i_dbl_y = dy << 1;
                dbl_pend = 1'b0;
            end else dbl_dly--;
        end
        if (add_pend) begin
            if (add_dly == 0) begin
                i_add_finish = 1'b1;
                i_add_x = ax1 + ax2;
                i_add_y = ay1 + ay2;
                add_pend = 1'b0;
            end else add_dly--;
        end
        if (o_dbl_start) begin
            if (!dbl_hang) begin
                dbl_pend = 1'b1; dbl_dly = 2; dx = o_dbl_x; dy = o_dbl_y;
            end
            n_dbl++;
            if (last_op == 2'd1) alt_bad++;
            last_op = 2'd1;
            ops_seq = {ops_seq[29:0], 2'd1};
        end
        if (o_add_start) begin
            add_pend = 1'b1; add_dly = 2;
            ax1 = o_add_x1; ay1 = o_add_y1; ax2 = o_add_x2; ay2 = o_add_y2;
            n_add++;
            if (last_op == 2'd2) alt_bad++;
            last_op = 2'd2;
            ops_seq = {ops_seq[29:0], 2'd2};
        end
        if (o_finished) fin_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        n_dbl = 0; n_add = 0; alt_bad = 0; fin_cnt = 0; last_op = 2'd0; ops_seq = '0;
    endtask

    // Issues a start and waits (bounded) for the finish pulse; cyc counts negedges from the start.
    task automatic run_op(input logic [W-1:0] k, input logic mid_start, output int cyc);
        clear_log();
        i_start = 1'b1; i_k = k; i_x = 8'd5; i_y = 8'd1;
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) i_start = 1'b0;
            if (mid_start && cyc == 10) begin i_start = 1'b1; i_k = 8'd1; end
            if (mid_start && cyc == 11) i_start = 1'b0;
            if (o_finished) break;
        end
        check("finish_within_bound", {31'd0, o_finished}, 32'd1);
        $display("run k=%0h cycles=%0d result=(%0h,%0h) dbl=%0d add=%0d", k, cyc, o_result_x, o_result_y, n_dbl, n_add);
    endtask

    int cyc;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_finished", {31'd0, o_finished}, 32'd0);
        check("rst_dbl_start", {31'd0, o_dbl_start}, 32'd0);
        check("rst_result_x", {24'd0, o_result_x}, 32'd0);
        check("rst_error", {31'd0, o_error}, 32'd0);
        i_rst = 1'b1;
        @(negedge clk);

        // k=1: no sub-ops, R=P, finish W+3 cycles after start
        run_op(8'd1, 1'b0, cyc);
        check("k1_latency", cyc, W + 3);
        check("k1_x", {24'd0, o_result_x}, 32'd5);
        check("k1_y", {24'd0, o_result_y}, 32'd1);
        check("k1_busy_at_pulse", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        check("k1_ops", n_dbl + n_add, 0);
        check("k1_fin_once", fin_cnt, 1);
        check("k1_fin_low", {31'd0, o_finished}, 32'd0);

        // k=0: infinity
        run_op(8'd0, 1'b0, cyc);
        check("k0_x", {24'd0, o_result_x}, 32'hFF);
        check("k0_y", {24'd0, o_result_y}, 32'd0);
        check("k0_ops", n_dbl + n_add, 0);
        check("k0_error", {31'd0, o_error}, 32'd0);

        // k=6: D, A, D; Q = (30, 6)
        run_op(8'd6, 1'b0, cyc);
        check("k6_seq", ops_seq, 32'h19);
        check("k6_x", {24'd0, o_result_x}, 32'd30);
        check("k6_y", {24'd0, o_result_y}, 32'd6);
        @(negedge clk);
        check("k6_busy_after", {31'd0, o_busy}, 32'd0);
        check("k6_result_hold", {24'd0, o_result_x}, 32'd30);

        // k=255 with a stray start mid-run: 7 D + 7 A alternating; Q = (251, 255)
        run_op(8'hFF, 1'b1, cyc);
        check("kff_dbl", n_dbl, W - 1);
        check("kff_add", n_add, W - 1);
        check("kff_alternate", alt_bad, 0);
        check("kff_x", {24'd0, o_result_x}, 32'hFB);
        check("kff_y", {24'd0, o_result_y}, 32'hFF);
        @(negedge clk);
        check("kff_fin_once", fin_cnt, 1);
        check("kff_no_restart", {31'd0, o_busy}, 32'd0);

        // Reset in DBL_WAIT; the stub's pending finish lands after release
        clear_log();
        i_start = 1'b1; i_k = 8'd6;
        @(negedge clk);
        i_start = 1'b0;
        for (int n = 0; n < 50 && !o_dbl_start; n++) @(negedge clk);
        check("rst_mid_reached_wait", {31'd0, o_dbl_start}, 32'd1);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        check("rst_mid_result", {24'd0, o_result_x}, 32'd0);
        check("rst_mid_dbl_x", {24'd0, o_dbl_x}, 32'd0);
        i_rst = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("stray_busy", {31'd0, o_busy}, 32'd0);
            check("stray_req", {30'd0, o_dbl_start, o_add_start}, 32'd0);
        end
        run_op(8'd3, 1'b0, cyc);
        check("k3_dbl", n_dbl, 1);
        check("k3_add", n_add, 1);
        check("k3_x", {24'd0, o_result_x}, 32'd15);
        check("k3_y", {24'd0, o_result_y}, 32'd3);

`ifdef ECC_SMUL_WATCHDOG_EN
        // Doubler never answers: abort after 16 WAIT cycles, then DONE
        clear_log();
        dbl_hang = 1'b1;
        i_start = 1'b1; i_k = 8'd3;
        @(negedge clk);
        i_start = 1'b0;
        for (int n = 0; n < 50 && !o_dbl_start; n++) @(negedge clk);
        cyc = 0;
        for (int n = 0; n < 100 && !o_finished; n++) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_latency", cyc, 17);
        check("wd_error", {31'd0, o_error}, 32'd1);
        check("wd_x", {24'd0, o_result_x}, 32'hFF);
        check("wd_y", {24'd0, o_result_y}, 32'd0);
        dbl_hang = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
